line_read_arbiter: RTL and testbench

Controller for the 128-bit line-buffer read path: holds one cached 128-bit line, arbitrates between the instruction-fetch and data read ports, and generates the byte-select mask that drives the line-to-16-bit extract datapath. On a miss, it fills the line from physical memory and then serves the request. The block sits between the fetch/MEM stages and the pmem interface, in front of the 16-bit extract unit.

---
 rtl/line_read_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_line_read_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_read_arbiter.sv
// line_read_arbiter
//
// Read-path controller for a single cached 128-bit line. Arbitrates between
// the instruction-fetch port (i_*) and the data read port (d_*), checks the
// granted address against the cached tag, fills the line from physical memory
// on a miss, and produces the byte-select mask that steers the external
// line-to-16-bit extract unit. The extract result (ext_data) is returned on
// the granted port in the response cycle.
//
// Ports
//   clk, reset_n        clock; synchronous active-low reset
//   i_read/i_addr       fetch request (word access, addr bit 0 ignored)
//   i_resp/i_rdata      one-cycle fetch response, data 0 when not responding
//   d_read/d_addr       data request
//   d_byte              1 = byte access (zero-extended by extract unit)
//   d_resp/d_rdata      one-cycle data response, data 0 when not responding
//   inv                 one-cycle pulse, invalidates the cached line
//   pmem_read           line fill request, held until pmem_resp
//   pmem_address        line-aligned fill address
//   pmem_rdata          fill line, sampled with pmem_resp
//   pmem_resp           fill complete
//   ext_line            cached line, to extract unit
//   ext_mask            byte-select mask, to extract unit (non-zero only in CHECK)
//   ext_data            extract unit result (combinational from ext_line/ext_mask)

module line_read_arbiter #(
    parameter int unsigned TAG_W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_read,
    input  logic [15:0]  i_addr,
    output logic         i_resp,
    output logic [15:0]  i_rdata,
    input  logic         d_read,
    input  logic [15:0]  d_addr,
    input  logic         d_byte,
    output logic         d_resp,
    output logic [15:0]  d_rdata,
    input  logic         inv,
    output logic         pmem_read,
    output logic [15:0]  pmem_address,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [127:0] ext_line,
    output logic [15:0]  ext_mask,
    input  logic [15:0]  ext_data
);

    // Byte offset within the 16-byte line occupies the address bits below the tag.
    localparam int unsigned OFF_W = 16 - TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FILL  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    state_t             state;
    state_t             state_next;
    port_t              grant;
    port_t              last_grant;
    port_t              arb_grant;
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [127:0]       line;

    logic               req_any;
    logic [15:0]        granted_addr;
    logic               granted_byte;
    logic               hit;
    logic [15:0]        word_mask;
    logic [15:0]        byte_mask;

    assign ext_line = line;

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    // Requesters hold address and d_byte stable until their response, so
    // the granted address is taken straight from the port rather than
    // being captured in a register.
    always_comb begin
        req_any      = i_read | d_read;
        granted_addr = (grant == PORT_I) ? i_addr : d_addr;
        granted_byte = (grant == PORT_D) && d_byte;
        hit          = valid && (tag == granted_addr[15:OFF_W]);
        word_mask    = 16'h0003 << {granted_addr[3:1], 1'b0};
        byte_mask    = 16'h0001 << granted_addr[3:0];
    end

    // On a tie the port that was not served last wins.
    always_comb begin
        if (i_read && d_read) begin
            arb_grant = (last_grant == PORT_D) ? PORT_I : PORT_D;
        end else if (i_read) begin
            arb_grant = PORT_I;
        end else begin
            arb_grant = PORT_D;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_any) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                state_next = hit ? IDLE : FILL;
            end
            FILL: begin
                // A fill always returns to CHECK; it hits there unless an
                // invalidate landed on the same edge as the fill.
                if (pmem_resp) begin
                    state_next = CHECK;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        i_resp       = 1'b0;
        i_rdata      = '0;
        d_resp       = 1'b0;
        d_rdata      = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;
        ext_mask     = '0;
        case (state)
            CHECK: begin
                ext_mask = granted_byte ? byte_mask : word_mask;
                if (hit) begin
                    if (grant == PORT_I) begin
                        i_resp  = 1'b1;
                        i_rdata = ext_data;
                    end else begin
                        d_resp  = 1'b1;
                        d_rdata = ext_data;
                    end
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {granted_addr[15:OFF_W], {OFF_W{1'b0}}};
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Line buffer, tag, valid and grant bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid      <= 1'b0;
            tag        <= '0;
            line       <= '0;
            grant      <= PORT_I;
            last_grant <= PORT_D;
        end else begin
            if (state == IDLE && req_any) begin
                grant <= arb_grant;
            end
            if (state == CHECK && hit) begin
                last_grant <= grant;
            end
            if (state == FILL && pmem_resp) begin
                line  <= pmem_rdata;
                tag   <= granted_addr[15:OFF_W];
                valid <= 1'b1;
            end
            // Invalidate is last so it wins over a fill completing on the
            // same edge: the line is written but left invalid and refetched.
            if (inv) begin
                valid <= 1'b0;
            end
        end
    end

    // Only one port can be granted, so the two responses are exclusive.
    assert property (@(posedge clk) disable iff (!reset_n) !(i_resp && d_resp));

endmodule

// File: tb/tb_line_read_arbiter.sv
// Directed testbench for line_read_arbiter. Models the external extract unit
// and memory, drives hand-built sequences and compares outputs against
// hand-computed values at posedge+1.

module tb_line_read_arbiter;

    logic         clk;
    logic         reset_n;
    logic         i_read;
    logic [15:0]  i_addr;
    logic         i_resp;
    logic [15:0]  i_rdata;
    logic         d_read;
    logic [15:0]  d_addr;
    logic         d_byte;
    logic         d_resp;
    logic [15:0]  d_rdata;
    logic         inv;
    logic         pmem_read;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [127:0] ext_line;
    logic [15:0]  ext_mask;
    logic [15:0]  ext_data;

    int checks;
    int errors;

    line_read_arbiter #(.TAG_W(12)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_addr       (d_addr),
        .d_byte       (d_byte),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .inv          (inv),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .ext_line     (ext_line),
        .ext_mask     (ext_mask),
        .ext_data     (ext_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Extract unit model: one mask bit -> zero-extended byte,
    // two adjacent bits -> little-endian halfword.
    int           ext_lo;
    logic [127:0] ext_shift;
    always_comb begin
        ext_lo    = 0;
        ext_data  = '0;
        for (int p = 15; p >= 0; p--) begin
            if (ext_mask[p]) ext_lo = p;
        end
        ext_shift = ext_line >> (8 * ext_lo);
        if ($countones(ext_mask) == 1) begin
            ext_data = {8'h00, ext_shift[7:0]};
        end else if ($countones(ext_mask) == 2) begin
            ext_data = ext_shift[15:0];
        end
    end

    // Line whose byte n holds base + n.
    function automatic logic [127:0] mk_line(input logic [7:0] base);
        logic [127:0] l;
        l = '0;
        for (int n = 0; n < 16; n++) begin
            l[8*n +: 8] = base + 8'(n);
        end
        return l;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        i_read     = 1'b0;
        i_addr     = '0;
        d_read     = 1'b0;
        d_addr     = '0;
        d_byte     = 1'b0;
        inv        = 1'b0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_i_resp",    32'(i_resp), 32'h0);
        check_eq("rst_d_resp",    32'(d_resp), 32'h0);
        check_eq("rst_i_rdata",   32'(i_rdata), 32'h0);
        check_eq("rst_d_rdata",   32'(d_rdata), 32'h0);
        check_eq("rst_pmem_read", 32'(pmem_read), 32'h0);
        check_eq("rst_pmem_addr", 32'(pmem_address), 32'h0);
        check_eq("rst_ext_mask",  32'(ext_mask), 32'h0);
        check_eq("rst_ext_line",  ext_line[31:0], 32'h0);
        reset_n = 1'b1;

        // Fetch miss on invalid buffer, fill, then hit
        i_addr = 16'h1234; i_read = 1'b1;
        check_eq("t1_c0_pmem_read", 32'(pmem_read), 32'h0);
        tick();
        check_eq("t1_c1_mask",      32'(ext_mask), 32'h0030);
        check_eq("t1_c1_i_resp",    32'(i_resp), 32'h0);
        check_eq("t1_c1_pmem_read", 32'(pmem_read), 32'h0);
        tick();
        check_eq("t1_c2_pmem_read", 32'(pmem_read), 32'h1);
        check_eq("t1_c2_pmem_addr", 32'(pmem_address), 32'h1230);
        tick();
        check_eq("t1_c3_pmem_read", 32'(pmem_read), 32'h1);
        check_eq("t1_c3_pmem_addr", 32'(pmem_address), 32'h1230);
        check_eq("t1_c3_i_resp",    32'(i_resp), 32'h0);
        pmem_rdata = mk_line(8'h00); pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t1_i_resp",       32'(i_resp), 32'h1);
        check_eq("t1_i_rdata",      32'(i_rdata), 32'h0504);
        check_eq("t1_mask",         32'(ext_mask), 32'h0030);
        check_eq("t1_pmem_read",    32'(pmem_read), 32'h0);
        check_eq("t1_d_resp",       32'(d_resp), 32'h0);
        tick();
        i_read = 1'b0;
        check_eq("t1_idle_i_resp",  32'(i_resp), 32'h0);
        check_eq("t1_idle_i_rdata", 32'(i_rdata), 32'h0);
        check_eq("t1_idle_mask",    32'(ext_mask), 32'h0);

        // Data byte hit at the top byte of the line
        d_addr = 16'h123F; d_byte = 1'b1; d_read = 1'b1;
        check_eq("t2_c0_pmem_read", 32'(pmem_read), 32'h0);
        tick();
        check_eq("t2_d_resp",       32'(d_resp), 32'h1);
        check_eq("t2_d_rdata",      32'(d_rdata), 32'h000F);
        check_eq("t2_mask",         32'(ext_mask), 32'h8000);
        check_eq("t2_pmem_read",    32'(pmem_read), 32'h0);
        check_eq("t2_i_resp",       32'(i_resp), 32'h0);
        tick();
        d_read = 1'b0; d_byte = 1'b0;
        check_eq("t2_idle_d_resp",  32'(d_resp), 32'h0);

        // Simultaneous hits: last served was D, so fetch goes first
        i_addr = 16'h1232; i_read = 1'b1;
        d_addr = 16'h1238; d_read = 1'b1;
        tick();
        check_eq("t3a_i_resp",      32'(i_resp), 32'h1);
        check_eq("t3a_i_rdata",     32'(i_rdata), 32'h0302);
        check_eq("t3a_d_resp",      32'(d_resp), 32'h0);
        tick();
        i_read = 1'b0;
        check_eq("t3a_idle_i_resp", 32'(i_resp), 32'h0);
        check_eq("t3a_idle_d_resp", 32'(d_resp), 32'h0);
        tick();
        check_eq("t3a_d_resp2",     32'(d_resp), 32'h1);
        check_eq("t3a_d_rdata",     32'(d_rdata), 32'h0908);
        check_eq("t3a_i_resp2",     32'(i_resp), 32'h0);
        tick();
        d_read = 1'b0;

        // Lone fetch makes I the last served port
        i_addr = 16'h123E; i_read = 1'b1;
        tick();
        check_eq("t3b_i_resp",      32'(i_resp), 32'h1);
        check_eq("t3b_i_rdata",     32'(i_rdata), 32'h0F0E);
        tick();
        i_read = 1'b0;

        // Next tie goes to data first
        i_addr = 16'h1230; i_read = 1'b1;
        d_addr = 16'h1231; d_byte = 1'b1; d_read = 1'b1;
        tick();
        check_eq("t3c_d_resp",      32'(d_resp), 32'h1);
        check_eq("t3c_d_rdata",     32'(d_rdata), 32'h0001);
        check_eq("t3c_i_resp",      32'(i_resp), 32'h0);
        tick();
        d_read = 1'b0; d_byte = 1'b0;
        tick();
        check_eq("t3c_i_resp2",     32'(i_resp), 32'h1);
        check_eq("t3c_i_rdata",     32'(i_rdata), 32'h0100);
        check_eq("t3c_d_resp2",     32'(d_resp), 32'h0);
        tick();
        i_read = 1'b0;

        // Data miss replaces the tag; old line then misses
        d_addr = 16'h2000; d_read = 1'b1;
        tick();
        check_eq("t4_c1_d_resp",    32'(d_resp), 32'h0);
        check_eq("t4_c1_mask",      32'(ext_mask), 32'h0003);
        tick();
        check_eq("t4_pmem_read",    32'(pmem_read), 32'h1);
        check_eq("t4_pmem_addr",    32'(pmem_address), 32'h2000);
        pmem_rdata = mk_line(8'h20); pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t4_d_resp",       32'(d_resp), 32'h1);
        check_eq("t4_d_rdata",      32'(d_rdata), 32'h2120);
        tick();
        d_read = 1'b0;
        i_addr = 16'h1230; i_read = 1'b1;
        tick();
        check_eq("t4b_c1_i_resp",   32'(i_resp), 32'h0);
        tick();
        check_eq("t4b_pmem_read",   32'(pmem_read), 32'h1);
        check_eq("t4b_pmem_addr",   32'(pmem_address), 32'h1230);
        tick();
        check_eq("t4b_wait_i_resp", 32'(i_resp), 32'h0);
        pmem_rdata = mk_line(8'h00); pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t4b_i_resp",      32'(i_resp), 32'h1);
        check_eq("t4b_i_rdata",     32'(i_rdata), 32'h0100);
        tick();
        i_read = 1'b0;

        // inv coincident with pmem_resp: line written but invalid, refetch
        i_addr = 16'h3004; i_read = 1'b1;
        tick();
        check_eq("t5_c1_i_resp",    32'(i_resp), 32'h0);
        tick();
        check_eq("t5_pmem_addr",    32'(pmem_address), 32'h3000);
        pmem_rdata = mk_line(8'h30); pmem_resp = 1'b1; inv = 1'b1;
        tick();
        pmem_resp = 1'b0; inv = 1'b0;
        check_eq("t5_check_miss",   32'(i_resp), 32'h0);
        check_eq("t5_line_written", ext_line[31:0], 32'h33323130);
        tick();
        check_eq("t5_refill_read",  32'(pmem_read), 32'h1);
        check_eq("t5_refill_addr",  32'(pmem_address), 32'h3000);
        check_eq("t5_refill_resp",  32'(i_resp), 32'h0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t5_i_resp",       32'(i_resp), 32'h1);
        check_eq("t5_i_rdata",      32'(i_rdata), 32'h3534);
        tick();
        i_read = 1'b0;

        // inv during CHECK: still hits on the pre-clear valid
        d_addr = 16'h3006; d_read = 1'b1;
        tick();
        inv = 1'b1;
        check_eq("t5b_d_resp",      32'(d_resp), 32'h1);
        check_eq("t5b_d_rdata",     32'(d_rdata), 32'h3736);
        tick();
        inv = 1'b0; d_read = 1'b0;
        check_eq("t5b_idle_d_resp", 32'(d_resp), 32'h0);
        d_read = 1'b1;
        tick();
        check_eq("t5c_miss_d_resp", 32'(d_resp), 32'h0);
        tick();
        check_eq("t5c_pmem_read",   32'(pmem_read), 32'h1);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t5c_d_resp",      32'(d_resp), 32'h1);
        check_eq("t5c_d_rdata",     32'(d_rdata), 32'h3736);
        tick();
        d_read = 1'b0;

        // Reset mid-FILL, then tie after reset: fetch wins and refetches
        i_addr = 16'h4000; i_read = 1'b1;
        tick();
        tick();
        check_eq("t6_pmem_read",    32'(pmem_read), 32'h1);
        reset_n = 1'b0;
        tick();
        check_eq("t6_rst_pmem_read", 32'(pmem_read), 32'h0);
        check_eq("t6_rst_pmem_addr", 32'(pmem_address), 32'h0);
        check_eq("t6_rst_i_resp",    32'(i_resp), 32'h0);
        check_eq("t6_rst_mask",      32'(ext_mask), 32'h0);
        reset_n = 1'b1;
        d_addr = 16'h4002; d_byte = 1'b0; d_read = 1'b1;
        tick();
        check_eq("t6_c1_i_resp",    32'(i_resp), 32'h0);
        check_eq("t6_c1_line_clr",  ext_line[31:0], 32'h0);
        check_eq("t6_c1_mask",      32'(ext_mask), 32'h0003);
        tick();
        check_eq("t6_refill_read",  32'(pmem_read), 32'h1);
        check_eq("t6_refill_addr",  32'(pmem_address), 32'h4000);
        pmem_rdata = mk_line(8'h40); pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0;
        check_eq("t6_i_resp",       32'(i_resp), 32'h1);
        check_eq("t6_i_rdata",      32'(i_rdata), 32'h4140);
        check_eq("t6_d_resp",       32'(d_resp), 32'h0);
        tick();
        i_read = 1'b0;
        check_eq("t6_idle_d_resp",  32'(d_resp), 32'h0);
        tick();
        check_eq("t6_d_resp2",      32'(d_resp), 32'h1);
        check_eq("t6_d_rdata",      32'(d_rdata), 32'h4342);
        tick();
        d_read = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
